// File: rtl/fp_addsub_issuer.sv
// Request-FIFO front end that issues single-precision add/sub operations to a
// multi-cycle unit and returns tagged results. Optional watchdog: FP_ISSUE_TIMEOUT_EN.
module fp_addsub_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_op,
    input  logic [31:0]                   req_a,
    input  logic [31:0]                   req_b,
    input  logic [TAG_W-1:0]              req_tag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic                          rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          fpu_start,
    output logic                          fpu_op,
    output logic [31:0]                   fpu_data_a,
    output logic [31:0]                   fpu_data_b,
    input  logic [31:0]                   fpu_data_o,
    input  logic                          fpu_busy,
    input  logic                          fpu_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 1 + 32 + 32 + TAG_W;
    localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] CNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    logic [EW-1:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [PW-1:0]    count_r;
    logic [PW-1:0]    count_s;
    logic             req_ready_r;
    logic             push_s;
    logic             nonempty_s;
    logic [EW-1:0]    head_s;

    state_t           state_r;
    state_t           state_s;
    logic             load_s;
    logic             start_s;
    logic             capture_s;
    logic             release_s;
    logic             timeout_s;

    logic             fpu_start_r;
    logic             fpu_op_r;
    logic [31:0]      fpu_a_r;
    logic [31:0]      fpu_b_r;
    logic [TAG_W-1:0] tag_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_data_r;
    logic [TAG_W-1:0] rsp_tag_r;

    assign push_s     = req_valid & req_ready_r;
    assign nonempty_s = (count_r != {PW{1'b0}});
    assign head_s     = mem_r[rd_ptr_r];

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_s = count_r;
        case ({push_s, load_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Request storage, written on an accepted push
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {req_op, req_a, req_b, req_tag};
        end
    end

    // FIFO pointers, occupancy and registered not-full
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {PW{1'b0}};
            req_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_s;
            req_ready_r <= (count_s != FULL_CNT);
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:      state_s = nonempty_s ? ISSUE : IDLE;
            ISSUE:     state_s = fpu_start_r ? WAIT_BUSY : ISSUE;
            WAIT_BUSY: begin
                if (timeout_s) begin
                    state_s = RESP;
                end else if (fpu_busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: state_s = (capture_s || timeout_s) ? RESP : WAIT_DONE;
            RESP:      state_s = rsp_ready ? IDLE : RESP;
            default:   state_s = IDLE;
        endcase
    end

    // FSM control strobes; start is pre-computed so the pulse leaves a register
    always_comb begin
        load_s    = 1'b0;
        start_s   = 1'b0;
        capture_s = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s  = nonempty_s;
                start_s = nonempty_s & fpu_ready & ~fpu_busy;
            end
            ISSUE:     start_s   = ~fpu_start_r & fpu_ready & ~fpu_busy;
            WAIT_BUSY: start_s   = 1'b0;
            WAIT_DONE: capture_s = fpu_ready & ~fpu_busy;
            RESP:      release_s = rsp_ready;
            default:   load_s    = 1'b0;
        endcase
    end

    // Unit-side operands and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            fpu_start_r <= 1'b0;
            fpu_op_r    <= 1'b0;
            fpu_a_r     <= 32'h0000_0000;
            fpu_b_r     <= 32'h0000_0000;
            tag_r       <= {TAG_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_tag_r   <= {TAG_W{1'b0}};
        end else begin
            fpu_start_r <= start_s;
            if (load_s) begin
                fpu_op_r <= head_s[EW-1];
                fpu_a_r  <= head_s[EW-2 -: 32];
                fpu_b_r  <= head_s[TAG_W+31 -: 32];
                tag_r    <= head_s[TAG_W-1:0];
            end
            if (capture_s) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= fpu_data_o;
                rsp_tag_r   <= tag_r;
            end else if (timeout_s) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= QNAN;
                rsp_tag_r   <= tag_r;
            end else if (release_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

`ifdef FP_ISSUE_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_cnt_r;
    logic        rsp_err_r;

    // A real completion in the same cycle wins over the watchdog
    assign timeout_s = ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) &&
                       (wd_cnt_r == TO_LIM) && !capture_s;
    assign rsp_err   = rsp_err_r;

    // Watchdog counter and error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_r  <= 16'd0;
            rsp_err_r <= 1'b0;
        end else begin
            if ((state_s == WAIT_BUSY) && (state_r != WAIT_BUSY)) begin
                wd_cnt_r <= 16'd0;
            end else if (((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) && (wd_cnt_r != TO_LIM)) begin
                wd_cnt_r <= wd_cnt_r + 16'd1;
            end
            if (timeout_s) begin
                rsp_err_r <= 1'b1;
            end else if (release_s) begin
                rsp_err_r <= 1'b0;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign req_ready  = req_ready_r;
    assign pending    = count_r;
    assign fpu_start  = fpu_start_r;
    assign fpu_op     = fpu_op_r;
    assign fpu_data_a = fpu_a_r;
    assign fpu_data_b = fpu_b_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_tag    = rsp_tag_r;

endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Directed bench for fp_addsub_issuer with a behavioural add/sub unit stub
// and a response scoreboard.
module tb_fp_addsub_issuer;

    localparam int FD = 4;
    localparam int TW = 4;
    localparam int TO = 40;
    localparam int PW = $clog2(FD) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [31:0]   req_a = 32'h0;
    logic [31:0]   req_b = 32'h0;
    logic [TW-1:0] req_tag = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic [PW-1:0] pending;
    logic          fpu_start;
    logic          fpu_op;
    logic [31:0]   fpu_data_a;
    logic [31:0]   fpu_data_b;
    logic [31:0]   fpu_data_o;
    logic          fpu_busy;
    logic          fpu_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_pushed = 0;
    int n_starts = 0;

    fp_addsub_issuer #(.FIFO_DEPTH(FD), .TAG_W(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .pending(pending),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_data_a(fpu_data_a),
        .fpu_data_b(fpu_data_b), .fpu_data_o(fpu_data_o),
        .fpu_busy(fpu_busy), .fpu_ready(fpu_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stub unit: known answers for the directed vectors, a fixed scramble otherwise
    function automatic logic [31:0] unit_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op == 1'b1 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == 1'b0 && a == 32'h40A0_0000 && b == 32'h4040_0000) return 32'h4000_0000;
        return a ^ {b[15:0], b[31:16]} ^ {32{op}};
    endfunction

    // Unit stub: samples operands the cycle after start, busy for st_lat more cycles
    logic        st_pend = 1'b0;
    logic        st_busy = 1'b0;
    logic        st_hang = 1'b0;
    logic [31:0] st_res  = 32'h0;
    int          st_cnt  = 0;
    int          st_lat  = 3;
    int          done_cyc = 0;

    assign fpu_busy   = st_pend | st_busy;
    assign fpu_ready  = ~fpu_busy;
    assign fpu_data_o = fpu_busy ? 32'h0 : st_res;

    always @(posedge clock) begin
        if (st_pend) begin
            st_res  <= unit_fn(fpu_op, fpu_data_a, fpu_data_b);
            st_busy <= 1'b1;
            st_cnt  <= st_lat;
            st_pend <= 1'b0;
        end else if (st_busy && !st_hang) begin
            if (st_cnt <= 1) begin
                st_busy  <= 1'b0;
                done_cyc <= cyc + 1;
            end else begin
                st_cnt <= st_cnt - 1;
            end
        end
        if (fpu_start) st_pend <= 1'b1;
    end

    // Scoreboard: {err,tag,data} per request and {op,a,b} per expected issue
    logic [36:0] rsp_q[$];
    logic [64:0] opq[$];
    logic [64:0] cur_ops = '0;
    logic        stab_en = 1'b0;
    logic        prev_start = 1'b0;

    always @(negedge clock) begin
        if (stab_en && fpu_busy)
            chk("operand_stable", {fpu_op, fpu_data_a, fpu_data_b}, cur_ops);
        if (fpu_start) begin
            chk("start_unit_idle", fpu_ready, 1'b1);
            chk("start_single", prev_start, 1'b0);
            chk("start_q_nonempty", opq.size() != 0, 1'b1);
            if (opq.size() != 0) begin
                chk("issue_ops", {fpu_op, fpu_data_a, fpu_data_b}, opq[0]);
                cur_ops <= opq.pop_front();
            end
            stab_en  <= 1'b1;
            n_starts <= n_starts + 1;
        end
        prev_start <= fpu_start;
        if (rsp_valid) begin
            chk("rsp_q_nonempty", rsp_q.size() != 0, 1'b1);
            if (rsp_q.size() != 0) begin
                chk("rsp_word", {rsp_err, rsp_tag, rsp_data}, rsp_q[0]);
                if (rsp_ready) rsp_q.pop_front();
            end
        end
        if (reset) begin
            rsp_q.delete();
            opq.delete();
            stab_en <= 1'b0;
        end
    end

    int acc_cyc;

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic sb_add(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tag, input logic [36:0] exp);
        rsp_q.push_back(exp);
        opq.push_back({op, a, b});
        n_pushed++;
        req_op = op; req_a = a; req_b = b; req_tag = tag;
        req_valid = 1'b1;
    endtask

    task automatic push_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TW-1:0] tag, input logic [36:0] exp);
        bit ok;
        ok = 1'b0;
        sb_add(op, a, b, tag, exp);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        chk("push_accept", ok, 1'b1);
        sync();
        req_valid = 1'b0;
    endtask

    task automatic wait_start(input int bound, output int sc);
        bit seen;
        seen = 1'b0;
        sc = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (fpu_start) begin
                seen = 1'b1;
                sc = cyc;
                break;
            end
        end
        chk("start_seen", seen, 1'b1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (rsp_q.size() == 0) break;
            @(negedge clock);
        end
        chk("drain", rsp_q.size(), 0);
        sync();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_tag"}, rsp_tag, 0);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_fpu_start"}, fpu_start, 1'b0);
        chk({tag, "_fpu_ops"}, {fpu_op, fpu_data_a, fpu_data_b}, 65'h0);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        int sc;
        int h;
        bit ok;
        logic [31:0] a;
        logic [31:0] b;
        logic op;

        // Reset
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset("reset");
        sync();
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", req_ready, 1'b1);
        sync();

        // 1.0 + 2.0, start latency and response latency
        push_req(1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd3, {1'b0, 4'd3, 32'h4040_0000});
        wait_start(20, sc);
        chk("start_latency", sc, acc_cyc + 2);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("rsp_seen", ok, 1'b1);
        chk("rsp_latency", cyc, done_cyc + 1);
        drain(40);

        // 5.0 - 3.0 with a slow unit, operands held while busy
        st_lat = 6;
        push_req(1'b0, 32'h40A0_0000, 32'h4040_0000, 4'd5, {1'b0, 4'd5, 32'h4000_0000});
        drain(60);

        // Backpressure: six requests with responses stalled
        st_lat = 2;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = (i % 2 == 1);
            a = 32'h4100_0000 + 32'(i) * 32'h0001_2345;
            b = 32'h3E00_0000 + 32'(i) * 32'h0010_0F0F;
            push_req(op, a, b, TW'(i), {1'b0, TW'(i), unit_fn(op, a, b)});
        end
        a = 32'h4100_0000 + 32'd5 * 32'h0001_2345;
        b = 32'h3E00_0000 + 32'd5 * 32'h0010_0F0F;
        sb_add(1'b1, a, b, 4'd5, {1'b0, 4'd5, unit_fn(1'b1, a, b)});
        repeat (8) @(negedge clock);
        chk("full_pending", pending, 4);
        chk("full_req_ready", req_ready, 1'b0);
        chk("stall_rsp_valid", rsp_valid, 1'b1);
        chk("stall_rsp_tag", rsp_tag, 0);
        sync();
        rsp_ready = 1'b1;
        h = cyc;
        sc = -1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fpu_start && sc < 0) sc = cyc;
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("tag5_accept", ok, 1'b1);
        chk("restart_after_rsp", sc, h + 2);
        sync();
        req_valid = 1'b0;
        drain(200);

        // Simultaneous push and pop at occupancy 2, pointers wrapping
        st_lat = 10;
        push_req(1'b1, 32'h1111_0000, 32'h0000_2222, 4'd8, {1'b0, 4'd8, unit_fn(1'b1, 32'h1111_0000, 32'h0000_2222)});
        push_req(1'b0, 32'h3333_0000, 32'h0000_4444, 4'd9, {1'b0, 4'd9, unit_fn(1'b0, 32'h3333_0000, 32'h0000_4444)});
        push_req(1'b1, 32'h5555_0000, 32'h0000_6666, 4'd10, {1'b0, 4'd10, unit_fn(1'b1, 32'h5555_0000, 32'h0000_6666)});
        @(negedge clock);
        chk("pp_pending_2", pending, 2);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rsp_valid && rsp_ready) begin ok = 1'b1; break; end
        end
        chk("pp_handshake_seen", ok, 1'b1);
        sync();
        sb_add(1'b0, 32'h7777_0000, 32'h0000_8888, 4'd11, {1'b0, 4'd11, unit_fn(1'b0, 32'h7777_0000, 32'h0000_8888)});
        @(negedge clock);
        chk("pp_req_ready", req_ready, 1'b1);
        chk("pp_pending_before", pending, 2);
        sync();
        req_valid = 1'b0;
        @(negedge clock);
        chk("pp_pending_after", pending, 2);
        drain(200);

        // Reset while waiting on a busy unit
        st_lat = 20;
        push_req(1'b1, 32'hABCD_0000, 32'h0000_1234, 4'd12, {1'b0, 4'd12, 32'h0});
        wait_start(20, sc);
        repeat (5) @(negedge clock);
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clock);
        check_reset("midop");
        chk("midop_unit_busy", fpu_busy, 1'b1);
        sync();
        push_req(1'b0, 32'h0F0F_0000, 32'h0000_F0F0, 4'd13, {1'b0, 4'd13, unit_fn(1'b0, 32'h0F0F_0000, 32'h0000_F0F0)});
        wait_start(60, sc);
        chk("post_reset_waits_idle", sc >= done_cyc, 1'b1);
        drain(100);

`ifdef FP_ISSUE_TIMEOUT_EN
        // Watchdog against a unit that never finishes
        st_lat = 2;
        st_hang = 1'b1;
        push_req(1'b1, 32'h1357_0000, 32'h0000_2468, 4'd14, {1'b1, 4'd14, 32'h7FC0_0000});
        ok = 1'b0;
        for (int i = 0; i < TO + 40; i++) begin
            @(negedge clock);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("timeout_rsp_seen", ok, 1'b1);
        chk("timeout_rsp_err", rsp_err, 1'b1);
        @(negedge clock);
        chk("timeout_err_cleared", rsp_err, 1'b0);
        sync();
        st_hang = 1'b0;
        drain(40);
`endif

        repeat (30) @(negedge clock);
        chk("start_count", n_starts, n_pushed);
        chk("ops_consumed", opq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_addsub_issuer.md
Name: fp_addsub_issuer

Overview:
- Initiator-side companion for the team's multi-cycle IEEE754 add/subtract unit.
- Accepts operation requests over a valid/ready stream and buffers them in a small FIFO.
- Drives the unit's start/op/data_a/data_b handshake, one operation in flight at a time.
- Captures each result and returns it with the request's tag over a valid/ready response stream.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
TAG_W, 4, width of request/response tag
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with FP_ISSUE_TIMEOUT_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready
req_op  in  1  1=add, 0=subtract (a-b)
req_a  in  32  operand A, IEEE754 single
req_b  in  32  operand B, IEEE754 single
req_tag  in  TAG_W  opaque request tag
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_data  out  32  result word
rsp_tag  out  TAG_W  tag of the completed request
rsp_err  out  1  watchdog fired (always 0 without macro)
pending  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
fpu_start  out  1  start pulse to add/sub unit
fpu_op  out  1  op to unit
fpu_data_a  out  32  operand A to unit
fpu_data_b  out  32  operand B to unit
fpu_data_o  in  32  unit result (valid only while unit idle)
fpu_busy  in  1  unit busy
fpu_ready  in  1  unit idle

Behaviour:
- Reset (synchronous, active-high):
  - FIFO flushed, FSM to IDLE.
  - fpu_start=0; fpu_op=0; fpu_data_a=0; fpu_data_b=0.
  - rsp_valid=0; rsp_data=0; rsp_tag=0; rsp_err=0; pending=0.
  - req_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons the in-flight op; the result is never returned.
  - The unit is not reset by this block; the ISSUE gating covers a unit still busy.
- FIFO:
  - req_ready = !full, registered.
  - Push on req_valid&req_ready; pop when IDLE moves to ISSUE.
  - Push and pop in the same cycle are allowed; pending is unchanged.
  - No push when full; pop never occurs when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: if FIFO non-empty, load head into fpu_op/fpu_data_a/fpu_data_b and tag register, pop, go ISSUE.
  - ISSUE: fpu_start=1 only while fpu_ready=1 and fpu_busy=0. After the start cycle go WAIT_BUSY; otherwise hold with start=0.
  - WAIT_BUSY: wait for fpu_busy=1, then go WAIT_DONE.
  - WAIT_DONE: on fpu_ready=1 and fpu_busy=0, register rsp_data<=fpu_data_o and rsp_tag<=tag register, set rsp_valid=1, go RESP.
  - RESP: hold rsp_valid/rsp_data/rsp_tag stable until rsp_ready=1, then rsp_valid=0 and go IDLE.
- fpu_start is high for exactly one cycle per operation.
- fpu_op/fpu_data_a/fpu_data_b stay stable from ISSUE until leaving WAIT_DONE, because the unit samples operands the cycle after start.
- Results are never captured while fpu_busy=1, since the unit drives 0 when busy.
- Latency:
  - Push at cycle t (FIFO empty, unit idle): fpu_start at t+2.
  - rsp_valid one cycle after the unit returns idle.
  - Next fpu_start at the earliest 2 cycles after the response handshake.
- Ordering: responses are returned strictly in request order.

Optional Feature:
- Macro FP_ISSUE_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entering WAIT_BUSY and increments each cycle in WAIT_BUSY/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES, go RESP with rsp_data=32'h7FC00000 (qNaN) and rsp_err=1.
  - rsp_err clears with the response handshake.
  - Before the next ISSUE start, the FSM still requires fpu_ready=1.
- When undefined: no counter; rsp_err tied 0; the FSM waits indefinitely.

Test Plan:
- Reset, then push {op=1, a=0x3F800000, b=0x40000000, tag=3}, rsp_ready=1 -> one fpu_start pulse, rsp_data=0x40400000, rsp_tag=3, rsp_err=0.
- Push {op=0, a=0x40A00000, b=0x40400000, tag=5} -> rsp_data=0x40000000, tag=5; fpu_data_a/b stable from start until unit idle.
- Hold rsp_ready=0, push 6 requests back-to-back -> one in flight plus 4 queued; pending=4, req_ready=0; rsp_data/tag stable. Release rsp_ready -> remaining responses in order, tags 0..5.
- Push and pop in the same cycle with FIFO at 2 -> pending stays 2; FIFO wraps past index FIFO_DEPTH-1 without corrupting data.
- Assert reset in WAIT_DONE while the unit is busy -> all outputs at reset values next cycle, pending=0; the next request waits for fpu_ready=1 before fpu_start.
- With FP_ISSUE_TIMEOUT_EN and a stub unit holding fpu_busy=1 -> after TIMEOUT_CYCLES, rsp_valid=1, rsp_data=0x7FC00000, rsp_err=1.
